// File: rtl/contador_bcd_mux.sv
// Two-digit BCD up/down counter with a time-multiplexed digit scan for a shared 7-segment encoder.
// Define CONTADOR_BCD_DOWN_EN to enable down-counting; otherwise the block counts up only.
module contador_bcd_mux #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       down,
  output logic [7:0] count,
  output logic       carry,
  output logic [3:0] bcd_out,
  output logic [1:0] dig_sel
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]        units_q, units_d;
  logic [3:0]        tens_q, tens_d;
  logic              carry_q, carry_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [1:0]        dig_sel_q, dig_sel_d;
  logic              dir_down;
  logic              scan_last;

`ifdef CONTADOR_BCD_DOWN_EN
  assign dir_down = down;
`else
  logic unused_down;
  assign unused_down = down;
  assign dir_down    = 1'b0;
`endif

  // Load sanitises each nibble independently so the digit registers stay decimal.
  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    carry_d = 1'b0;
    if (load) begin
      units_d = (load_val[3:0] > 4'd9) ? 4'd0 : load_val[3:0];
      tens_d  = (load_val[7:4] > 4'd9) ? 4'd0 : load_val[7:4];
    end else if (en) begin
      if (dir_down) begin
        if (units_q != 4'd0) begin
          units_d = units_q - 4'd1;
        end else begin
          units_d = 4'd9;
          if (tens_q != 4'd0) begin
            tens_d = tens_q - 4'd1;
          end else begin
            tens_d  = 4'd9;
            carry_d = 1'b1;
          end
        end
      end else begin
        if (units_q != 4'd9) begin
          units_d = units_q + 4'd1;
        end else begin
          units_d = 4'd0;
          if (tens_q != 4'd9) begin
            tens_d = tens_q + 4'd1;
          end else begin
            tens_d  = 4'd0;
            carry_d = 1'b1;
          end
        end
      end
    end
  end

  // The scan runs free of en/load so the display never freezes on one digit.
  assign scan_last = (scan_q == SCAN_W'(SCAN_DIV - 1));

  always_comb begin
    scan_d    = scan_last ? '0 : scan_q + SCAN_W'(1);
    dig_sel_d = scan_last ? {dig_sel_q[0], dig_sel_q[1]} : dig_sel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      units_q   <= 4'd0;
      tens_q    <= 4'd0;
      carry_q   <= 1'b0;
      scan_q    <= '0;
      dig_sel_q <= 2'b01;
    end else begin
      units_q   <= units_d;
      tens_q    <= tens_d;
      carry_q   <= carry_d;
      scan_q    <= scan_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  assign count   = {tens_q, units_q};
  assign carry   = carry_q;
  assign dig_sel = dig_sel_q;
  assign bcd_out = dig_sel_q[1] ? tens_q : units_q;

endmodule
